// File: rtl/multicycle_control_fsm.sv
// Main controller for the multicycle MIPS datapath: one state per cycle,
// Moore outputs, and interrupt entry at instruction boundaries.
module multicycle_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_JAL   = 6'b000011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       irq,
  input  logic       int_enable,
  output logic [1:0] aluControl,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSource,
  output logic [1:0] regWrite,
  output logic [1:0] regDst,
  output logic [1:0] memToReg,
  output logic       isInterrupted,
  output logic       isBranch,
  output logic       pcWrite,
  output logic       lorD,
  output logic       memWrite,
  output logic       IrWrite,
  output logic       int_ack,
  output logic       illegal_op
);

  localparam logic [4:0] S_RST       = 5'd0;
  localparam logic [4:0] S_FETCH     = 5'd1;
  localparam logic [4:0] S_DECODE    = 5'd2;
  localparam logic [4:0] S_MEMADR    = 5'd3;
  localparam logic [4:0] S_MEMRD     = 5'd4;
  localparam logic [4:0] S_MEMWB     = 5'd5;
  localparam logic [4:0] S_MEMWR     = 5'd6;
  localparam logic [4:0] S_EXEC      = 5'd7;
  localparam logic [4:0] S_ALUWB     = 5'd8;
  localparam logic [4:0] S_BRANCH    = 5'd9;
  localparam logic [4:0] S_ADDIEX    = 5'd10;
  localparam logic [4:0] S_ADDIWB    = 5'd11;
  localparam logic [4:0] S_JUMP      = 5'd12;
  localparam logic [4:0] S_JAL       = 5'd13;
  localparam logic [4:0] S_ILLEGAL   = 5'd14;
  localparam logic [4:0] S_INT_SAVE  = 5'd15;
  localparam logic [4:0] S_INT_FETCH = 5'd16;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;

  typedef struct packed {
    logic [1:0] alu_control;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       is_interrupted;
    logic       is_branch;
    logic       pc_write;
    logic       lor_d;
    logic       mem_write;
    logic       ir_write;
    logic       int_ack;
    logic       illegal_op;
  } ctl_t;

  function automatic logic funct_legal(input logic [5:0] fn);
    logic ok;
    case (fn)
      F_ADD, F_SUB, F_AND, F_OR: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [1:0] alu_for_funct(input logic [5:0] fn);
    logic [1:0] ac;
    case (fn)
      F_ADD:   ac = 2'b00;
      F_SUB:   ac = 2'b01;
      F_AND:   ac = 2'b10;
      F_OR:    ac = 2'b11;
      default: ac = 2'b00;
    endcase
    return ac;
  endfunction

  // Control word for a given state; every field not named stays zero.
  function automatic ctl_t decode_outputs(input logic [4:0] st, input logic [5:0] fn);
    ctl_t c;
    c = '0;
    case (st)
      S_FETCH, S_INT_FETCH: begin
        c.alu_src_b      = 2'b01;
        c.pc_write       = 1'b1;
        c.ir_write       = 1'b1;
        c.is_interrupted = (st == S_INT_FETCH);
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: c.lor_d = 1'b1;
      S_MEMWB: begin
        c.reg_write  = 2'b01;
        c.mem_to_reg = 2'b01;
      end
      S_MEMWR: begin
        c.lor_d     = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a   = 2'b01;
        c.alu_control = alu_for_funct(fn);
      end
      S_ALUWB: begin
        c.reg_write = 2'b01;
        c.reg_dst   = 2'b01;
      end
      S_BRANCH: begin
        c.alu_src_a   = 2'b01;
        c.alu_control = 2'b01;
        c.is_branch   = 1'b1;
        c.pc_source   = 2'b01;
      end
      S_ADDIWB: c.reg_write = 2'b01;
      S_JUMP: begin
        c.pc_source = 2'b10;
        c.pc_write  = 1'b1;
      end
      S_JAL: begin
        c.reg_write  = 2'b01;
        c.reg_dst    = 2'b10;
        c.mem_to_reg = 2'b10;
        c.pc_source  = 2'b10;
        c.pc_write   = 1'b1;
      end
      S_ILLEGAL: c.illegal_op = 1'b1;
      S_INT_SAVE: begin
        c.int_ack    = 1'b1;
        c.reg_write  = 2'b01;
        c.reg_dst    = 2'b10;
        c.mem_to_reg = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  logic [4:0] state_r;
  logic [4:0] next_state_s;
  logic [4:0] next_fetch_s;
  logic       irq_pending_r;
  ctl_t       ctl_r;

  // Instruction boundary target: a pending or live enabled interrupt wins over FETCH.
  always_comb begin
    if (irq_pending_r || (irq && int_enable)) begin
      next_fetch_s = S_INT_SAVE;
    end else begin
      next_fetch_s = S_FETCH;
    end
  end

  // Next-state sequencing.
  always_comb begin
    next_state_s = S_RST;
    case (state_r)
      S_RST:       next_state_s = S_FETCH;
      S_FETCH:     next_state_s = S_DECODE;
      S_INT_FETCH: next_state_s = S_DECODE;
      S_DECODE: begin
        if ((op == OP_LW) || (op == OP_SW)) begin
          next_state_s = S_MEMADR;
        end else if (op == OP_RTYPE) begin
          next_state_s = S_EXEC;
        end else if (op == OP_BEQ) begin
          next_state_s = S_BRANCH;
        end else if (op == OP_ADDI) begin
          next_state_s = S_ADDIEX;
        end else if (op == OP_J) begin
          next_state_s = S_JUMP;
        end else if (op == OP_JAL) begin
          next_state_s = S_JAL;
        end else begin
          next_state_s = S_ILLEGAL;
        end
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          next_state_s = S_MEMRD;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_MEMRD: next_state_s = S_MEMWB;
      S_EXEC: begin
        if (funct_legal(funct)) begin
          next_state_s = S_ALUWB;
        end else begin
          next_state_s = S_ILLEGAL;
        end
      end
      S_ADDIEX:   next_state_s = S_ADDIWB;
      S_INT_SAVE: next_state_s = S_INT_FETCH;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB,
      S_JUMP, S_JAL, S_ILLEGAL: next_state_s = next_fetch_s;
      default:    next_state_s = S_RST;
    endcase
  end

  // State register; outputs are registered from the next state so they track state exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_RST;
      ctl_r   <= '0;
    end else begin
      state_r <= next_state_s;
      ctl_r   <= decode_outputs(next_state_s, funct);
    end
  end

  // Interrupt latch; entering INT_SAVE clears it even if irq is sampled on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_pending_r <= 1'b0;
    end else if (next_state_s == S_INT_SAVE) begin
      irq_pending_r <= 1'b0;
    end else if (irq && int_enable) begin
      irq_pending_r <= 1'b1;
    end else begin
      irq_pending_r <= irq_pending_r;
    end
  end

  assign aluControl    = ctl_r.alu_control;
  assign aluSrcA       = ctl_r.alu_src_a;
  assign aluSrcB       = ctl_r.alu_src_b;
  assign pcSource      = ctl_r.pc_source;
  assign regWrite      = ctl_r.reg_write;
  assign regDst        = ctl_r.reg_dst;
  assign memToReg      = ctl_r.mem_to_reg;
  assign isInterrupted = ctl_r.is_interrupted;
  assign isBranch      = ctl_r.is_branch;
  assign pcWrite       = ctl_r.pc_write;
  assign lorD          = ctl_r.lor_d;
  assign memWrite      = ctl_r.mem_write;
  assign IrWrite       = ctl_r.ir_write;
  assign int_ack       = ctl_r.int_ack;
  assign illegal_op    = ctl_r.illegal_op;

endmodule
